sr_bank_rr_controller: RTL

//  Round-robin controller sharing one WIDTH-bit bank of sr_flipflop cells among NREQ requesters.

---
 rtl/sr_bank_rr_controller_pkg.sv | 16 +
 rtl/sr_bank_rr_controller_if.sv | 16 +
 rtl/sr_bank_rr_controller_bank.sv | 34 +++
 rtl/sr_bank_rr_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sr_bank_rr_controller_pkg.sv
// Shared opcodes and FSM state encodings for the round-robin S/R bank controller.
package sr_bank_rr_controller_pkg;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/sr_bank_rr_controller_if.sv
// Request/grant/data bundle between requesters (master) and the bank controller (slave).
interface sr_bank_rr_controller_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [WIDTH-1:0]      q;

    modport master (output req, op, data, input gnt, ack, busy, q);
    modport slave  (input req, op, data, output gnt, ack, busy, q);
endinterface

// File: rtl/sr_bank_rr_controller_bank.sv
// Reset-less storage bank: one S/R flip-flop per bit, cleared by the controller's INIT pass.
module sr_flipflop (
    input  logic i_clk,
    input  logic i_s,
    input  logic i_r,
    output logic o_q
);
    // S/R cell update; S=R=1 is kept away by the controller and treated as hold.
    always_ff @(posedge i_clk) begin
        case ({i_s, i_r})
            2'b10:   o_q <= 1'b1;
            2'b01:   o_q <= 1'b0;
            default: o_q <= o_q;
        endcase
    end
endmodule

module sr_bank #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] i_sr_s,
    input  logic [WIDTH-1:0] i_sr_r,
    output logic [WIDTH-1:0] o_q
);
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        sr_flipflop u_cell (
            .i_clk (i_clk),
            .i_s   (i_sr_s[g]),
            .i_r   (i_sr_r[g]),
            .o_q   (o_q[g])
        );
    end
endmodule

// File: rtl/sr_bank_rr_controller.sv
// Round-robin arbiter + INIT/IDLE/ISSUE/ACK FSM turning granted commands into S/R vectors.
module sr_bank_rr_controller
    import sr_bank_rr_controller_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    sr_bank_rr_controller_if.slave  bus
);
    localparam int PTR_W = $clog2(NREQ);

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt, r_win, w_win_nxt, w_arb_idx;
    logic               w_arb_any;
    logic [NREQ-1:0]    r_gnt, w_gnt_nxt, r_ack, w_ack_nxt;
    logic [WIDTH-1:0]   r_sr_s, r_sr_r, w_sr_s_nxt, w_sr_r_nxt;
    logic [WIDTH-1:0]   w_bank_s, w_bank_r, w_q, w_win_data;
    logic [1:0]         w_win_op;
    logic               r_busy, w_busy_nxt, r_init_clr;

    // Packs {S, R}; every branch keeps S and R disjoint bit by bit.
    function automatic logic [2*WIDTH-1:0] sr_encode(input logic [1:0] op,
                                                     input logic [WIDTH-1:0] d,
                                                     input logic [WIDTH-1:0] q);
        case (op)
            OP_LOAD:   sr_encode = {d, ~d};
            OP_SET:    sr_encode = {d, {WIDTH{1'b0}}};
            OP_CLEAR:  sr_encode = {{WIDTH{1'b0}}, d};
            OP_TOGGLE: sr_encode = {d & ~q, d & q};
            default:   sr_encode = {2*WIDTH{1'b0}};
        endcase
    endfunction

    // Rotating priority search starting one past the last served requester.
    always_comb begin
        logic [PTR_W-1:0] v_try;
        v_try     = {PTR_W{1'b0}};
        w_arb_idx = {PTR_W{1'b0}};
        w_arb_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            v_try = PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_arb_any && bus.req[v_try]) begin
                w_arb_any = 1'b1;
                w_arb_idx = v_try;
            end else begin
                w_arb_any = w_arb_any;
            end
        end
    end

    // Selects the current winner's opcode and data field.
    always_comb begin
        w_win_op   = 2'b00;
        w_win_data = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_idx == PTR_W'(i)) begin
                w_win_op   = bus.op[2*i +: 2];
                w_win_data = bus.data[WIDTH*i +: WIDTH];
            end else begin
                w_win_op   = w_win_op;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  w_state_nxt = ST_IDLE;
            ST_IDLE:  w_state_nxt = w_arb_any ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        w_gnt_nxt  = {NREQ{1'b0}};
        w_ack_nxt  = {NREQ{1'b0}};
        w_sr_s_nxt = {WIDTH{1'b0}};
        w_sr_r_nxt = {WIDTH{1'b0}};
        w_ptr_nxt  = r_ptr;
        w_win_nxt  = r_win;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_gnt_nxt                = {{(NREQ-1){1'b0}}, 1'b1} << w_arb_idx;
                    {w_sr_s_nxt, w_sr_r_nxt} = sr_encode(w_win_op, w_win_data, w_q);
                    w_win_nxt                = w_arb_idx;
                end else begin
                    w_win_nxt = r_win;
                end
            end
            ST_ISSUE: w_ack_nxt = r_gnt;
            ST_ACK:   w_ptr_nxt = r_win;
            default:  w_ptr_nxt = r_ptr;
        endcase
    end

    // Output and bookkeeping registers; reset discards any S/R vector in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt      <= {NREQ{1'b0}};
            r_ack      <= {NREQ{1'b0}};
            r_sr_s     <= {WIDTH{1'b0}};
            r_sr_r     <= {WIDTH{1'b0}};
            r_ptr      <= PTR_W'(NREQ - 1);
            r_win      <= {PTR_W{1'b0}};
            r_busy     <= 1'b1;
            r_init_clr <= 1'b1;
        end else begin
            r_gnt      <= w_gnt_nxt;
            r_ack      <= w_ack_nxt;
            r_sr_s     <= w_sr_s_nxt;
            r_sr_r     <= w_sr_r_nxt;
            r_ptr      <= w_ptr_nxt;
            r_win      <= w_win_nxt;
            r_busy     <= w_busy_nxt;
            r_init_clr <= 1'b0;
        end
    end

    // r_init_clr is high exactly for the INIT cycle, so the bank clears on the edge leaving INIT.
    assign w_bank_s = r_sr_s & ~{WIDTH{r_init_clr}};
    assign w_bank_r = r_sr_r | {WIDTH{r_init_clr}};

    sr_bank #(.WIDTH(WIDTH)) u_bank (
        .i_clk  (i_clk),
        .i_sr_s (w_bank_s),
        .i_sr_r (w_bank_r),
        .o_q    (w_q)
    );

    assign bus.gnt  = r_gnt;
    assign bus.ack  = r_ack;
    assign bus.busy = r_busy;
    assign bus.q    = w_q;

endmodule
